demux_rr_scheduler: RTL and testbench

//   Scheduler that sits in front of the 1-to-4 demux (one_four) and routes a single

---
 rtl/demux_rr_scheduler.sv | 139 +++++++++++++
 tb/tb_demux_rr_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_scheduler.sv
// Scheduler in front of the 1-to-4 demux: accepts one valid/ready word,
// picks a channel (round-robin over enabled channels, or caller-addressed),
// then holds select and data until that channel accepts the word.

// One channel's offer flag: raised when a word is committed to this channel,
// dropped at the edge where the channel accepts it.
module demux_rr_lane #(
    parameter logic [1:0] CH = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] tgt,
    input  logic       ready,
    output logic       valid
);

    // Offer flag: set on commit to this channel, cleared on acceptance.
    always_ff @(posedge clk) begin
        if (rst)
            valid <= 1'b0;
        else if (load && (tgt == CH))
            valid <= 1'b1;
        else if (ready)
            valid <= 1'b0;
    end

endmodule

module demux_rr_scheduler #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic             mode,
    input  logic [3:0]       en_mask,
    output logic [1:0]       s,
    output logic [W-1:0]     out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int NUM_CH = 4;

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state;
    logic [1:0] ptr;       // round-robin start point, moves only on completion
    logic [1:0] rr_tgt;
    logic       rr_hit;
    logic [1:0] tgt;
    logic       accept;
    logic       drop;      // addressed word aimed at a disabled channel
    logic       take;      // accepted word that will be sent
    logic       done;      // served channel accepts the held word this edge

    // Round-robin search: first enabled channel starting at ptr. Walking the
    // offsets from far to near lets the nearest enabled one win.
    always_comb begin
        logic [1:0] idx;
        rr_tgt = ptr;
        rr_hit = 1'b0;
        idx    = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (en_mask[idx]) begin
                rr_tgt = idx;
                rr_hit = 1'b1;
            end
        end
    end

    // Target and handshake decode; inputs only matter while IDLE.
    always_comb begin
        tgt      = mode ? in_sel : rr_tgt;
        in_ready = (state == IDLE) && (mode || rr_hit);
        accept   = in_valid && in_ready;
        drop     = accept && mode && !en_mask[in_sel];
        take     = accept && !drop;
        done     = (state == SEND) && out_ready[s];
    end

    // Control FSM with registered select, data, status and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            s        <= 2'd0;
            out_data <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            err <= drop;
            case (state)
                IDLE: begin
                    if (take) begin
                        out_data <= in_data;
                        s        <= tgt;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    // The committed word is never redirected; only its
                    // channel's ready ends the transfer.
                    if (done) begin
                        ptr      <= s + 2'd1;
                        xfer_cnt <= xfer_cnt + 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel offer flags form the one-hot out_valid.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        demux_rr_lane #(.CH(2'(c))) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (take),
            .tgt   (tgt),
            .ready (out_ready[c]),
            .valid (out_valid[c])
        );
    end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: directed scenarios plus random traffic,
// expected routing pushed to a scoreboard queue and checked by a monitor.
module tb_demux_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic       mode;
    logic [3:0] en_mask;
    logic [1:0] s;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
    logic       err;
    logic [7:0] xfer_cnt;

    demux_rr_scheduler #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_sel(in_sel), .mode(mode), .en_mask(en_mask),
        .s(s), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err), .xfer_cnt(xfer_cnt)
    );

    typedef struct {
        bit         is_err;
        logic [1:0] ch;
        logic [7:0] data;
        logic [7:0] cnt_before;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         fails  = 0;
    int         m_ptr  = 0;
    logic [7:0] m_cnt  = 8'd0;
    int         vcyc   = 0;
    int         last_vcyc = 0;
    bit         ordy_rand = 1'b0;
    logic [3:0] ordy_fixed = 4'hF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Consumer side: out_ready changes just after each rising edge.
    initial begin
        out_ready = 4'h0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ordy_rand ? 4'($urandom) : ordy_fixed;
        end
    end

    // Monitor: compares every offered word and every err pulse with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (err === 1'b1) begin
                if (q.size() == 0 || !q[0].is_err) begin
                    chk("unexpected_err", 32'(err), 32'd0);
                end else begin
                    chk("err_out_valid", 32'(out_valid), 32'd0);
                    chk("err_xfer_cnt", 32'(xfer_cnt), 32'(q[0].cnt_before));
                    void'(q.pop_front());
                end
            end
            if (out_valid !== 4'h0) begin
                vcyc++;
                if (q.size() == 0 || q[0].is_err) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_valid_onehot", 32'(out_valid), 32'(4'b0001 << q[0].ch));
                    chk("sel_s", 32'(s), 32'(q[0].ch));
                    chk("out_data", 32'(out_data), 32'(q[0].data));
                    chk("busy_send", 32'(busy), 32'd1);
                    chk("in_ready_send", 32'(in_ready), 32'd0);
                    if (out_ready[q[0].ch]) begin
                        chk("xfer_cnt_pre", 32'(xfer_cnt), 32'(q[0].cnt_before));
                        void'(q.pop_front());
                        last_vcyc = vcyc;
                        vcyc = 0;
                    end
                end
            end
        end else begin
            vcyc = 0;
        end
    end

    // Present one word in IDLE, predict its fate, then scramble the sampled-in-IDLE inputs.
    task automatic issue(input logic m, input logic [1:0] sel, input logic [3:0] mask,
                         input logic [7:0] d);
        exp_t e;
        logic exp_rdy;
        @(posedge clk);
        #1;
        mode = m; in_sel = sel; en_mask = mask; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        exp_rdy = m | (|mask);
        chk("in_ready_idle", 32'(in_ready), 32'(exp_rdy));
        if (!exp_rdy) begin
            repeat (3) begin
                @(negedge clk);
                chk("in_ready_nomask", 32'(in_ready), 32'd0);
                chk("out_valid_nomask", 32'(out_valid), 32'd0);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        if (in_ready !== 1'b1) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        e.is_err = 1'b0;
        e.ch = 2'd0;
        e.data = d;
        e.cnt_before = m_cnt;
        if (m) begin
            if (!mask[sel]) e.is_err = 1'b1;
            else e.ch = sel;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (mask[c]) begin
                    e.ch = 2'(c);
                    break;
                end
            end
        end
        if (!e.is_err) begin
            m_ptr = (int'(e.ch) + 1) % 4;
            m_cnt = m_cnt + 8'd1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode = 1'($urandom);
        en_mask = 4'($urandom);
        in_sel = 2'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_sel = 2'd0;
        mode = 1'b0; en_mask = 4'hF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin over all channels, always-ready consumers
        ordy_fixed = 4'hF;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 2'd0, 4'hF, 8'hA1 + 8'(i));
            wait_drain();
            chk("rr_hold_cycles", 32'(last_vcyc), 32'd1);
        end
        @(negedge clk);
        chk("rr_xfer_cnt5", 32'(xfer_cnt), 32'd5);

        // Sparse mask, then no enabled channel
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 2'd0, 4'b1010, 8'h10 + 8'(i));
            wait_drain();
        end
        issue(1'b0, 2'd0, 4'h0, 8'h77);

        // Addressed word held while its channel stalls for 3 cycles
        ordy_fixed = 4'b1011;
        issue(1'b1, 2'd2, 4'hF, 8'h5C);
        repeat (3) @(posedge clk);
        #1 ordy_fixed = 4'hF;
        wait_drain();
        chk("stall_hold_cycles", 32'(last_vcyc), 32'd4);
        @(negedge clk);
        chk("stall_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));

        // Addressed word to a disabled channel is dropped with err
        issue(1'b1, 2'd0, 4'b1110, 8'h33);
        wait_drain();
        @(negedge clk);
        chk("drop_err_cleared", 32'(err), 32'd0);
        chk("drop_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));

        // Reset while a word is held on channel 2
        ordy_fixed = 4'h0;
        issue(1'b1, 2'd2, 4'hF, 8'hC2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_ptr = 0;
        m_cnt = 8'd0;
        @(negedge clk);
        chk("rst_send_out_valid", 32'(out_valid), 32'd0);
        chk("rst_send_s", 32'(s), 32'd0);
        chk("rst_send_xfer", 32'(xfer_cnt), 32'd0);
        ordy_fixed = 4'hF;
        issue(1'b0, 2'd3, 4'hF, 8'hE0);
        wait_drain();

        // Random traffic with random consumer readiness
        ordy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 2) == 0), 2'($urandom), 4'($urandom), 8'($urandom));
            wait_drain();
        end
        @(negedge clk);
        chk("final_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
